// File: rtl/lsu_ctrl.sv
// Load/store control stage: accepts one request, checks length/alignment/range,
// drives the byte-lane memory port for the needed cycles, and returns a result
// or an exception. Extension and byte steering live in the memory block.
`timescale 1ns/1ps

`ifndef ML_BYTE
`define ML_BYTE 2'd0
`endif
`ifndef ML_HALF
`define ML_HALF 2'd1
`endif
`ifndef ML_WORD
`define ML_WORD 2'd2
`endif

module lsu_ctrl #(
    parameter int ADDRW  = 12,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    // request from execute
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic             req_sign,
    input  logic [1:0]       req_len,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    // result to pipeline
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_exc,
    output logic [1:0]       resp_cause,
    // memory port
    output logic             mem_we,
    output logic             mem_sign,
    output logic [1:0]       mem_length,
    output logic [ADDRW-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_MISAL = 2'd1;
    localparam logic [1:0] CAUSE_RANGE = 2'd2;
    localparam logic [1:0] CAUSE_LEN   = 2'd3;

    // Count value on which the load data is valid at the memory port.
    localparam logic [1:0] LAST_CNT = 2'(RD_LAT);

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             we_q, we_d;
    logic             sign_q, sign_d;
    logic [1:0]       len_q, len_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             exc_q, exc_d;
    logic [1:0]       cause_q, cause_d;

    logic             len_bad;
    logic             misal;
    logic             out_rng;
    logic [1:0]       cause_in;

    // Request checks in priority order: illegal length, misalignment, range.
    always_comb begin
        len_bad  = (req_len != `ML_BYTE) && (req_len != `ML_HALF) && (req_len != `ML_WORD);
        misal    = ((req_len == `ML_HALF) && req_addr[0]) ||
                   ((req_len == `ML_WORD) && (req_addr[1:0] != 2'b00));
        out_rng  = (req_addr[31:ADDRW] != '0);
        cause_in = len_bad ? CAUSE_LEN   :
                   misal   ? CAUSE_MISAL :
                   out_rng ? CAUSE_RANGE : CAUSE_NONE;
    end

    // Next-state and datapath updates; everything holds unless a state acts on it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sign_d  = sign_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        cause_d = cause_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // Only the in-range part of the address is kept; a request with
                    // nonzero upper bits never reaches ACCESS.
                    we_d    = req_we;
                    sign_d  = req_sign;
                    len_d   = req_len;
                    addr_d  = req_addr[ADDRW-1:0];
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (cause_in != CAUSE_NONE) begin
                        exc_d   = 1'b1;
                        cause_d = cause_in;
                        state_d = RESP;
                    end else begin
                        exc_d   = 1'b0;
                        cause_d = CAUSE_NONE;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    // Store: single write cycle, result data stays zero.
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == LAST_CNT) begin
                        rdata_d = mem_rdata;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-field registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            len_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            exc_q   <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sign_q  <= sign_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
        end
    end

    // Handshakes come straight from state; memory fields hold their latched values,
    // only the write enable is qualified by ACCESS.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_rdata = rdata_q;
        resp_exc   = exc_q;
        resp_cause = cause_q;
        mem_we     = (state_q == ACCESS) && we_q;
        mem_sign   = sign_q;
        mem_length = len_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: three instances (RD_LAT 1, 0, 3) each with a byte-lane
// memory model; a driver pushes expected responses into a scoreboard queue and
// a monitor compares whenever a response is presented.
`timescale 1ns/1ps

module tb_lsu_ctrl;

    localparam int N = 3;
    localparam logic [1:0] LB = 2'd0, LH = 2'd1, LW = 2'd2;

    int lats [N] = '{1, 0, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]        rst;
    logic [N-1:0]        req_valid, req_ready, req_we, req_sign;
    logic [N-1:0][1:0]   req_len;
    logic [N-1:0][31:0]  req_addr, req_wdata;
    logic [N-1:0]        resp_valid, resp_ready, resp_exc;
    logic [N-1:0][31:0]  resp_rdata;
    logic [N-1:0][1:0]   resp_cause;
    logic [N-1:0]        mem_we, mem_sign;
    logic [N-1:0][1:0]   mem_length;
    logic [N-1:0][11:0]  mem_addr;
    logic [N-1:0][31:0]  mem_wdata, mem_rdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vecs = 0;
    int fails = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 0 : 3;

        lsu_ctrl #(.ADDRW(12), .RD_LAT(LAT)) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .req_sign   (req_sign[g]),
            .req_len    (req_len[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_exc   (resp_exc[g]),
            .resp_cause (resp_cause[g]),
            .mem_we     (mem_we[g]),
            .mem_sign   (mem_sign[g]),
            .mem_length (mem_length[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g])
        );

        // Byte-lane memory, little endian, with sign/zero extension on reads.
        logic [7:0]  mem [4096];
        logic [11:0] a0, a1, a2, a3;
        logic [31:0] rd_comb, p1, p2, p3;

        always_comb begin
            a0 = mem_addr[g];
            a1 = a0 + 12'd1;
            a2 = a0 + 12'd2;
            a3 = a0 + 12'd3;
            case (mem_length[g])
                LB:      rd_comb = mem_sign[g] ? {{24{mem[a0][7]}}, mem[a0]} : {24'h0, mem[a0]};
                LH:      rd_comb = mem_sign[g] ? {{16{mem[a1][7]}}, mem[a1], mem[a0]}
                                               : {16'h0, mem[a1], mem[a0]};
                default: rd_comb = {mem[a3], mem[a2], mem[a1], mem[a0]};
            endcase
        end

        always @(posedge clk) begin
            if (mem_we[g]) begin
                mem[a0] <= mem_wdata[g][7:0];
                if (mem_length[g] != LB) mem[a1] <= mem_wdata[g][15:8];
                if (mem_length[g] == LW) begin
                    mem[a2] <= mem_wdata[g][23:16];
                    mem[a3] <= mem_wdata[g][31:24];
                end
            end
            p1 <= rd_comb;
            p2 <= p1;
            p3 <= p2;
        end

        assign mem_rdata[g] = (LAT == 0) ? rd_comb : (LAT == 1) ? p1 : (LAT == 2) ? p2 : p3;
    end

    typedef struct {
        int          k;
        logic [31:0] rdata;
        logic        exc;
        logic [1:0]  cause;
        int          lat;
        int          nwe;
        int          acc;
    } exp_t;

    exp_t sbq[$];

    int  wecnt [N];
    bit  seen  [N];

    // Monitor: checks every presented response against the queue head; the
    // handshake cycle also checks write-pulse count and pops the entry.
    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (rst[g]) begin
                wecnt[g] = 0;
                seen[g]  = 0;
            end else begin
                if (mem_we[g]) wecnt[g]++;
                if (resp_valid[g]) begin
                    if (sbq.size() == 0 || sbq[0].k != g) begin
                        if (resp_ready[g]) chk($sformatf("u%0d unexpected_resp", g), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sbq[0];
                        if (!seen[g]) begin
                            seen[g] = 1;
                            chk($sformatf("u%0d latency", g), 32'(cyc - e.acc + 1), 32'(e.lat));
                        end
                        chk($sformatf("u%0d rdata", g), resp_rdata[g], e.rdata);
                        chk($sformatf("u%0d exc", g), {31'h0, resp_exc[g]}, {31'h0, e.exc});
                        chk($sformatf("u%0d cause", g), {30'h0, resp_cause[g]}, {30'h0, e.cause});
                        chk($sformatf("u%0d req_ready_in_resp", g), {31'h0, req_ready[g]}, 32'd0);
                        if (resp_ready[g]) begin
                            chk($sformatf("u%0d mem_we_pulses", g), 32'(wecnt[g]), 32'(e.nwe));
                            void'(sbq.pop_front());
                            seen[g]  = 0;
                            wecnt[g] = 0;
                        end
                    end
                end
            end
        end
    end

    // Driver: called just after a posedge; holds the request until accepted.
    task automatic send(input int k, input logic we, input logic sign, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] erd, input logic [1:0] ecause, input bit expect_resp);
        exp_t e;
        int   n;
        req_we[k]    = we;
        req_sign[k]  = sign;
        req_len[k]   = len;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_valid[k] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[k]) begin
            chk($sformatf("u%0d accept_timeout", k), 32'd0, 32'd1);
        end else if (expect_resp) begin
            e.k     = k;
            e.rdata = erd;
            e.cause = ecause;
            e.exc   = (ecause != 2'd0);
            e.lat   = e.exc ? 1 : we ? 2 : lats[k] + 2;
            e.nwe   = (we && !e.exc) ? 1 : 0;
            e.acc   = cyc + 1;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() > 0) begin
            chk("drain_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        #1;
    endtask

    // Directed scenarios shared by all latency variants.
    task automatic run_basic(input int k);
        send(k, 1, 0, LW,    32'h010, 32'hDEADBEEF, 32'h0,        2'd0, 1);
        send(k, 0, 0, LW,    32'h010, 32'h0,        32'hDEADBEEF, 2'd0, 1);
        send(k, 1, 0, LW,    32'h020, 32'h0,        32'h0,        2'd0, 1);
        send(k, 1, 0, LB,    32'h021, 32'h80,       32'h0,        2'd0, 1);
        send(k, 0, 1, LB,    32'h021, 32'h0,        32'hFFFFFF80, 2'd0, 1);
        send(k, 0, 0, LB,    32'h021, 32'h0,        32'h00000080, 2'd0, 1);
        send(k, 0, 0, LH,    32'h003, 32'h0,        32'h0,        2'd1, 1);
        send(k, 1, 0, LW,    32'h002, 32'h12345678, 32'h0,        2'd1, 1);
        send(k, 0, 0, LW,    32'h1000, 32'h0,       32'h0,        2'd2, 1);
        send(k, 0, 0, 2'b11, 32'h001, 32'h0,        32'h0,        2'd3, 1);
        send(k, 0, 0, LW,    32'h010, 32'h0,        32'hDEADBEEF, 2'd0, 1);
        drain();
    endtask

    initial begin
        rst        = '1;
        req_valid  = '0;
        req_we     = '0;
        req_sign   = '0;
        req_len    = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        rst = '0;

        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("u%0d rst_req_ready", g),  {31'h0, req_ready[g]},  32'd1);
            chk($sformatf("u%0d rst_resp_valid", g), {31'h0, resp_valid[g]}, 32'd0);
            chk($sformatf("u%0d rst_resp_exc", g),   {31'h0, resp_exc[g]},   32'd0);
            chk($sformatf("u%0d rst_resp_cause", g), {30'h0, resp_cause[g]}, 32'd0);
            chk($sformatf("u%0d rst_resp_rdata", g), resp_rdata[g],          32'd0);
            chk($sformatf("u%0d rst_mem_we", g),     {31'h0, mem_we[g]},     32'd0);
        end
        @(posedge clk);
        #1;

        for (int k = 0; k < N; k++) run_basic(k);

        // Back-pressure: response held three cycles, next request waits behind it.
        resp_ready[0] = 1'b0;
        send(0, 0, 0, LW, 32'h010, 32'h0, 32'hDEADBEEF, 2'd0, 1);
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                resp_ready[0] = 1'b1;
            end
        join_none
        send(0, 0, 1, LH, 32'h020, 32'h0, 32'hFFFF8000, 2'd0, 1);
        drain();

        // Reset during the second ACCESS cycle of a load drops the request.
        for (int k = 0; k < N; k++) begin
            send(k, 0, 0, LW, 32'h010, 32'h0, 32'h0, 2'd0, 0);
            if (lats[k] >= 1) begin
                @(posedge clk);
                #1;
            end
            rst[k] = 1'b1;
            @(posedge clk);
            #1;
            rst[k] = 1'b0;
            @(negedge clk);
            chk($sformatf("u%0d post_rst_resp_valid", k), {31'h0, resp_valid[k]}, 32'd0);
            chk($sformatf("u%0d post_rst_req_ready", k),  {31'h0, req_ready[k]},  32'd1);
            chk($sformatf("u%0d post_rst_mem_we", k),     {31'h0, mem_we[k]},     32'd0);
            @(posedge clk);
            #1;
            send(k, 0, 0, LW, 32'h010, 32'h0, 32'hDEADBEEF, 2'd0, 1);
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
